reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Central reset controller for the avionics FPGA. It collects the reset sources: the external reset button, the software/watchdog request and PLL lock loss. It holds every subsystem in reset for a minimum time, waits for clock lock, then releases per-domain resets in a fixed order with programmable spacing. It latches the cause and count of resets for housekeeping telemetry.

Parameters:
N_DOMAINS, 4, number of downstream reset domains; bit 0 is released first.
STEP_CYCLES, 48, CLK_48MHZ cycles between successive domain releases (1 us).
DEBOUNCE_CYCLES, 480, consecutive synchronized-high samples required to accept EXT_RESET (10 us).
MIN_HOLD_CYCLES, 4800, minimum cycles all domains stay in reset after the last request (100 us).

Ports:
CLK_48MHZ  in  1  system clock, sole clock.
RESET  in  1  synchronous, active-high power-on reset.
EXT_RESET  in  1  asynchronous, active-high external reset button; bouncy.
SW_RESET_REQ  in  1  single-cycle synchronous software/watchdog reset request.
PLL_LOCK  in  1  asynchronous PLL lock indicator, high = locked.
DOMAIN_RESET  out  N_DOMAINS  active-high per-domain resets, registered.
SYS_READY  out  1  high when all domains are released, registered.
RESET_CAUSE  out  2  cause of the last reset: 0 power-on, 1 external, 2 software, 3 PLL loss.
RESET_COUNT  out  8  resets since power-on (excluding power-on), saturating at 255.

Behaviour:
- RESET=1 puts the block in: state HOLD, hold counter 0, DOMAIN_RESET all ones, SYS_READY 0, RESET_CAUSE 0, RESET_COUNT 0, synchronizers and debounce cleared.
- EXT_RESET and PLL_LOCK each pass through a 2-FF synchronizer, giving 2 cycles of latency.
- ext_req asserts once the synchronized EXT_RESET has been high for DEBOUNCE_CYCLES consecutive cycles. Any low sample clears the debounce counter and deasserts ext_req on the next cycle.
- HOLD state:
  - All DOMAIN_RESET bits are 1.
  - The hold counter counts up to MIN_HOLD_CYCLES-1.
  - Any ext_req or SW_RESET_REQ restarts the counter at 0; a held button keeps the block in HOLD indefinitely.
  - At terminal count with no request, go to WAIT_LOCK.
  - PLL_LOCK is ignored in HOLD.
- WAIT_LOCK state:
  - All DOMAIN_RESET bits are 1.
  - Go to SEQ on the cycle the synchronized lock is 1.
  - ext_req or SW_RESET_REQ goes to HOLD.
- SEQ state:
  - The step counter counts 0..STEP_CYCLES-1.
  - At terminal count, clear DOMAIN_RESET[idx] and increment idx.
  - After bit N_DOMAINS-1 is cleared, go to RUN; SYS_READY=1 from the cycle after the last release.
- RUN state: DOMAIN_RESET all 0, SYS_READY 1.
- Reset entry (from WAIT_LOCK, SEQ or RUN into HOLD):
  - Causes: ext_req, SW_RESET_REQ, or synchronized lock = 0 (lock loss applies in SEQ/RUN only).
  - On the next clock, DOMAIN_RESET goes all ones, SYS_READY 0, and idx and the counters reset.
  - RESET_CAUSE is latched on entry only. Priority on simultaneous sources: external > PLL loss > software.
  - RESET_COUNT increments once per entry and saturates at 255.
  - Requests arriving while already in HOLD restart the hold counter but change neither RESET_CAUSE nor RESET_COUNT.
- Outputs change only on CLK_48MHZ edges and are glitch-free registers.
- Counter widths are $clog2 of the respective parameter (minimum 1).
- MIN_HOLD_CYCLES, STEP_CYCLES and DEBOUNCE_CYCLES must be at least 1.

Decomposition:
- Package avionics_rst_pkg holds:
  - state encoding: HOLD, WAIT_LOCK, SEQ, RUN;
  - cause codes: CAUSE_POR, CAUSE_EXT, CAUSE_SW, CAUSE_PLL;
  - the RESET_COUNT width constant.
- Sub-module rst_sync_debounce (parameter DEBOUNCE) holds the 2-FF synchronizer plus the consecutive-sample counter.
  - Instantiated with DEBOUNCE_CYCLES for EXT_RESET.
  - Instantiated with DEBOUNCE=1 (plain synchronizer) for PLL_LOCK.

Test Plan:
All scenarios use N_DOMAINS=4, STEP=4, DEBOUNCE=8, MIN_HOLD=16.
1. Power-on: RESET high 5 cycles with PLL_LOCK=1 throughout, then low -> DOMAIN_RESET stays 1111 for 16 cycles. It then steps 1110, 1100, 1000, 0000 at 4-cycle spacing. SYS_READY rises 1 cycle after 0000; CAUSE=0, COUNT=0.
2. Bounce: in RUN, pulse EXT_RESET high 5 cycles, low 2, high 5 -> no reset, SYS_READY stays 1. Then hold it high 12 cycles -> DOMAIN_RESET=1111 about 10 cycles after the rising edge; CAUSE=1, COUNT=1; re-sequencing starts 16 cycles after ext_req drops.
3. Software request: in RUN, assert SW_RESET_REQ one cycle -> next cycle DOMAIN_RESET=1111, SYS_READY=0, CAUSE=2, COUNT increments. A second SW pulse 10 cycles later restarts the 16-cycle hold; COUNT is unchanged.
4. Lock loss: drop PLL_LOCK while in SEQ with DOMAIN_RESET=1100 -> 3 cycles later 1111 and CAUSE=3. Hold completes and the block waits in WAIT_LOCK until PLL_LOCK returns; SEQ starts 2 cycles after lock returns.
5. Simultaneous sources: ext_req debounce completing on the same cycle as SW_RESET_REQ with PLL_LOCK low -> CAUSE=1, COUNT increments by exactly 1.
6. Saturation: force 300 SW resets -> RESET_COUNT=255. Assert RESET mid-SEQ -> next cycle all outputs at reset values, COUNT=0.

Source files
------------

// File: rtl/avionics_rst_pkg.sv
// Shared types and constants for the central reset sequencer.
package avionics_rst_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    SEQ       = 2'd2,
    RUN       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_EXT = 2'd1,
    CAUSE_SW  = 2'd2,
    CAUSE_PLL = 2'd3
  } cause_e;

  localparam int unsigned COUNT_W = 8;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_sync_debounce.sv
// Two-flop synchronizer followed by a consecutive-high-sample qualifier.
// DEBOUNCE=1 degenerates to a plain synchronizer.
module rst_sync_debounce
  import avionics_rst_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

  logic            r_meta;
  logic            r_sync;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      if (!r_sync) begin
        r_cnt <= '0;
      end else if (r_cnt != CntLast) begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  // High on the DEBOUNCE-th consecutive synchronized-high cycle and onwards.
  assign o_level = r_sync && (r_cnt == CntLast);

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: minimum hold, wait for PLL lock, ordered per-domain
// release, with latched reset cause and saturating reset count.
module reset_sequencer
  import avionics_rst_pkg::*;
#(
  parameter int unsigned N_DOMAINS       = 4,
  parameter int unsigned STEP_CYCLES     = 48,
  parameter int unsigned DEBOUNCE_CYCLES = 480,
  parameter int unsigned MIN_HOLD_CYCLES = 4800
) (
  input  logic                 CLK_48MHZ,
  input  logic                 RESET,
  input  logic                 EXT_RESET,
  input  logic                 SW_RESET_REQ,
  input  logic                 PLL_LOCK,
  output logic [N_DOMAINS-1:0] DOMAIN_RESET,
  output logic                 SYS_READY,
  output logic [1:0]           RESET_CAUSE,
  output logic [COUNT_W-1:0]   RESET_COUNT
);

  localparam int unsigned HoldW = cnt_width(MIN_HOLD_CYCLES);
  localparam int unsigned StepW = cnt_width(STEP_CYCLES);
  localparam int unsigned IdxW  = cnt_width(N_DOMAINS);

  localparam logic [HoldW-1:0] HoldLast = HoldW'(MIN_HOLD_CYCLES - 1);
  localparam logic [StepW-1:0] StepLast = StepW'(STEP_CYCLES - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(N_DOMAINS - 1);

  logic w_ext_req;
  logic w_lock;

  rst_sync_debounce #(
    .DEBOUNCE(DEBOUNCE_CYCLES)
  ) u_ext_sync (
    .i_clk  (CLK_48MHZ),
    .i_rst  (RESET),
    .i_async(EXT_RESET),
    .o_level(w_ext_req)
  );

  rst_sync_debounce #(
    .DEBOUNCE(1)
  ) u_lock_sync (
    .i_clk  (CLK_48MHZ),
    .i_rst  (RESET),
    .i_async(PLL_LOCK),
    .o_level(w_lock)
  );

  state_e               r_state;
  logic [HoldW-1:0]     r_hold_cnt;
  logic [StepW-1:0]     r_step_cnt;
  logic [IdxW-1:0]      r_idx;
  logic [N_DOMAINS-1:0] r_dom_rst;
  logic                 r_sys_ready;
  cause_e               r_cause;
  logic [COUNT_W-1:0]   r_count;

  state_e               w_state_nxt;
  logic [HoldW-1:0]     w_hold_nxt;
  logic [StepW-1:0]     w_step_nxt;
  logic [IdxW-1:0]      w_idx_nxt;
  logic [N_DOMAINS-1:0] w_dom_nxt;
  logic                 w_ready_nxt;
  cause_e               w_cause_nxt;
  logic [COUNT_W-1:0]   w_count_nxt;

  logic w_req;
  logic w_pll_loss;
  logic w_entry;

  assign w_req      = w_ext_req | SW_RESET_REQ;
  // Lock loss only counts once the domains have started coming out of reset.
  assign w_pll_loss = !w_lock && ((r_state == SEQ) || (r_state == RUN));

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_step_nxt  = r_step_cnt;
    w_idx_nxt   = r_idx;
    w_dom_nxt   = r_dom_rst;
    w_ready_nxt = r_sys_ready;
    w_cause_nxt = r_cause;
    w_count_nxt = r_count;
    w_entry     = 1'b0;

    unique case (r_state)
      HOLD: begin
        w_dom_nxt   = '1;
        w_ready_nxt = 1'b0;
        if (w_req) begin
          w_hold_nxt = '0;
        end else if (r_hold_cnt == HoldLast) begin
          w_hold_nxt  = '0;
          w_state_nxt = WAIT_LOCK;
        end else begin
          w_hold_nxt = r_hold_cnt + HoldW'(1);
        end
      end
      WAIT_LOCK: begin
        w_dom_nxt   = '1;
        w_ready_nxt = 1'b0;
        if (w_req) begin
          w_entry = 1'b1;
        end else if (w_lock) begin
          w_state_nxt = SEQ;
          w_step_nxt  = '0;
          w_idx_nxt   = '0;
        end
      end
      SEQ: begin
        w_ready_nxt = 1'b0;
        if (w_req || w_pll_loss) begin
          w_entry = 1'b1;
        end else if (r_step_cnt == StepLast) begin
          w_step_nxt       = '0;
          w_dom_nxt[r_idx] = 1'b0;
          w_idx_nxt        = r_idx + IdxW'(1);
          if (r_idx == IdxLast) begin
            w_state_nxt = RUN;
          end
        end else begin
          w_step_nxt = r_step_cnt + StepW'(1);
        end
      end
      RUN: begin
        w_dom_nxt   = '0;
        w_ready_nxt = 1'b1;
        if (w_req || w_pll_loss) begin
          w_entry = 1'b1;
        end
      end
      default: w_state_nxt = HOLD;
    endcase

    if (w_entry) begin
      w_state_nxt = HOLD;
      w_hold_nxt  = '0;
      w_step_nxt  = '0;
      w_idx_nxt   = '0;
      w_dom_nxt   = '1;
      w_ready_nxt = 1'b0;
      if (w_ext_req) begin
        w_cause_nxt = CAUSE_EXT;
      end else if (w_pll_loss) begin
        w_cause_nxt = CAUSE_PLL;
      end else begin
        w_cause_nxt = CAUSE_SW;
      end
      if (r_count != '1) begin
        w_count_nxt = r_count + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (RESET) begin
      r_state     <= HOLD;
      r_hold_cnt  <= '0;
      r_step_cnt  <= '0;
      r_idx       <= '0;
      r_dom_rst   <= '1;
      r_sys_ready <= 1'b0;
      r_cause     <= CAUSE_POR;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_step_cnt  <= w_step_nxt;
      r_idx       <= w_idx_nxt;
      r_dom_rst   <= w_dom_nxt;
      r_sys_ready <= w_ready_nxt;
      r_cause     <= w_cause_nxt;
      r_count     <= w_count_nxt;
    end
  end

  assign DOMAIN_RESET = r_dom_rst;
  assign SYS_READY    = r_sys_ready;
  assign RESET_CAUSE  = r_cause;
  assign RESET_COUNT  = r_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with N_DOMAINS=4, STEP=4, DEBOUNCE=8, MIN_HOLD=16.
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       ext_rst;
  logic       sw_req;
  logic       pll_lock;
  logic [3:0] dom_rst;
  logic       sys_ready;
  logic [1:0] cause;
  logic [7:0] count;

  int n_checks = 0;
  int n_pass   = 0;

  reset_sequencer #(
    .N_DOMAINS      (4),
    .STEP_CYCLES    (4),
    .DEBOUNCE_CYCLES(8),
    .MIN_HOLD_CYCLES(16)
  ) dut (
    .CLK_48MHZ   (clk),
    .RESET       (rst),
    .EXT_RESET   (ext_rst),
    .SW_RESET_REQ(sw_req),
    .PLL_LOCK    (pll_lock),
    .DOMAIN_RESET(dom_rst),
    .SYS_READY   (sys_ready),
    .RESET_CAUSE (cause),
    .RESET_COUNT (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst      = 1'b1;
    ext_rst  = 1'b0;
    sw_req   = 1'b0;
    pll_lock = 1'b1;

    // Power-on
    repeat (5) tick();
    chk("por_dom", 32'(dom_rst), 32'hF);
    chk("por_ready", 32'(sys_ready), 32'h0);
    chk("por_cause", 32'(cause), 32'h0);
    chk("por_count", 32'(count), 32'h0);
    rst = 1'b0;
    repeat (20) tick();
    chk("hold_dom", 32'(dom_rst), 32'hF);
    tick();
    chk("seq_bit0", 32'(dom_rst), 32'hE);
    repeat (3) tick();
    chk("seq_spacing", 32'(dom_rst), 32'hE);
    tick();
    chk("seq_bit1", 32'(dom_rst), 32'hC);
    repeat (4) tick();
    chk("seq_bit2", 32'(dom_rst), 32'h8);
    repeat (4) tick();
    chk("seq_bit3", 32'(dom_rst), 32'h0);
    chk("ready_lag", 32'(sys_ready), 32'h0);
    tick();
    chk("ready", 32'(sys_ready), 32'h1);
    chk("run_cause", 32'(cause), 32'h0);
    chk("run_count", 32'(count), 32'h0);

    // Bouncy button must not reset
    ext_rst = 1'b1; repeat (5) tick();
    ext_rst = 1'b0; repeat (2) tick();
    ext_rst = 1'b1; repeat (5) tick();
    ext_rst = 1'b0; repeat (4) tick();
    chk("bounce_ready", 32'(sys_ready), 32'h1);
    chk("bounce_dom", 32'(dom_rst), 32'h0);

    // Held button: 2 sync + 8 debounce, entry on the following edge
    ext_rst = 1'b1;
    repeat (9) tick();
    chk("ext_pre", 32'(dom_rst), 32'h0);
    tick();
    chk("ext_dom", 32'(dom_rst), 32'hF);
    chk("ext_ready", 32'(sys_ready), 32'h0);
    chk("ext_cause", 32'(cause), 32'h1);
    chk("ext_count", 32'(count), 32'h1);
    repeat (2) tick();
    ext_rst = 1'b0;
    repeat (22) tick();
    chk("ext_hold", 32'(dom_rst), 32'hF);
    tick();
    chk("ext_reseq", 32'(dom_rst), 32'hE);
    repeat (13) tick();
    chk("ext_run", 32'(sys_ready), 32'h1);

    // Software request, then a second request during hold
    sw_req = 1'b1; tick(); sw_req = 1'b0;
    chk("sw_dom", 32'(dom_rst), 32'hF);
    chk("sw_ready", 32'(sys_ready), 32'h0);
    chk("sw_cause", 32'(cause), 32'h2);
    chk("sw_count", 32'(count), 32'h2);
    repeat (9) tick();
    sw_req = 1'b1; tick(); sw_req = 1'b0;
    chk("sw2_count", 32'(count), 32'h2);
    chk("sw2_cause", 32'(cause), 32'h2);
    repeat (10) tick();
    chk("sw2_restart", 32'(dom_rst), 32'hF);
    repeat (10) tick();
    chk("sw2_hold", 32'(dom_rst), 32'hF);
    tick();
    chk("sw2_reseq", 32'(dom_rst), 32'hE);

    // Lock loss mid-sequence
    repeat (4) tick();
    chk("pll_pre", 32'(dom_rst), 32'hC);
    pll_lock = 1'b0;
    repeat (2) tick();
    chk("pll_lat", 32'(dom_rst), 32'hC);
    tick();
    chk("pll_dom", 32'(dom_rst), 32'hF);
    chk("pll_cause", 32'(cause), 32'h3);
    chk("pll_count", 32'(count), 32'h3);
    repeat (30) tick();
    chk("pll_wait", 32'(dom_rst), 32'hF);
    chk("pll_wait_ready", 32'(sys_ready), 32'h0);
    pll_lock = 1'b1;
    repeat (6) tick();
    chk("lock_seq_pre", 32'(dom_rst), 32'hF);
    tick();
    chk("lock_seq", 32'(dom_rst), 32'hE);
    repeat (13) tick();
    chk("lock_run", 32'(sys_ready), 32'h1);

    // All three sources land on the same cycle
    ext_rst = 1'b1;
    repeat (7) tick();
    pll_lock = 1'b0;
    repeat (2) tick();
    chk("sim_pre", 32'(dom_rst), 32'h0);
    sw_req = 1'b1; tick(); sw_req = 1'b0;
    ext_rst = 1'b0;
    chk("sim_dom", 32'(dom_rst), 32'hF);
    chk("sim_cause", 32'(cause), 32'h1);
    chk("sim_count", 32'(count), 32'h4);
    repeat (4) tick();
    chk("sim_count_hold", 32'(count), 32'h4);

    // Saturation: software resets from WAIT_LOCK with the PLL unlocked
    repeat (30) tick();
    for (int i = 0; i < 300; i++) begin
      sw_req = 1'b1; tick(); sw_req = 1'b0;
      repeat (20) tick();
      if (i == 9) chk("sat_count_10", 32'(count), 32'd14);
      if (i == 250) chk("sat_count_reach", 32'(count), 32'd255);
    end
    chk("sat_count", 32'(count), 32'd255);
    chk("sat_cause", 32'(cause), 32'h2);

    // Power-on reset mid-sequence
    pll_lock = 1'b1;
    repeat (8) tick();
    chk("rst_pre", 32'(dom_rst), 32'hE);
    rst = 1'b1; tick();
    chk("rst_dom", 32'(dom_rst), 32'hF);
    chk("rst_ready", 32'(sys_ready), 32'h0);
    chk("rst_cause", 32'(cause), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
